frame_filler: RTL and testbench

- Downstream stage of the graphics command processor. On one FF_valid/FF_ready handshake it latches a fill colour and a frame base, then writes that colour to every visible pixel of the frame in DRAM.
- Writes go through the DRAM request controller's address FIFO (af) and write-data FIFO (wdf).
- One burst = 1 address command + 2 × 128-bit data words = 8 pixels of 32 bits each.

---
 rtl/frame_filler.sv | 94 +++++++++
 tb/tb_frame_filler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_filler.sv
// Fills every visible pixel of a frame with one colour, issuing 8-pixel
// bursts (one address command plus two 128-bit beats) in row-major order.
module frame_filler #(
  parameter int H_PIXELS = 800,
  parameter int V_PIXELS = 600
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         FF_valid,
  input  logic [23:0]  FF_color,
  input  logic [31:0]  FF_frame,
  output logic         FF_ready,
  input  logic         af_full,
  output logic         af_wr_en,
  output logic [30:0]  af_addr_din,
  input  logic         wdf_full,
  output logic         wdf_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din
);

  localparam logic [6:0] LAST_COL = 7'(H_PIXELS / 8 - 1);
  localparam logic [9:0] LAST_ROW = 10'(V_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA2} state_t;

  state_t      r_state;
  logic        r_ready;
  logic [23:0] r_color;
  logic [5:0]  r_frame;
  logic [6:0]  r_col;
  logic [9:0]  r_row;

  logic w_cmd_push;
  logic w_beat2_push;

  // Enables are gated combinationally so a full flag in the same cycle
  // always suppresses the push.
  assign w_cmd_push   = (r_state == S_CMD) && !af_full && !wdf_full;
  assign w_beat2_push = (r_state == S_DATA2) && !wdf_full;

  assign FF_ready     = r_ready;
  assign af_wr_en     = w_cmd_push;
  assign wdf_wr_en    = w_cmd_push || w_beat2_push;
  assign af_addr_din  = {6'b0, r_frame, r_row, r_col, 2'b00};
  assign wdf_din      = {4{8'h00, r_color}};
  assign wdf_mask_din = 16'h0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_color <= '0;
      r_frame <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (FF_valid && r_ready) begin
            r_color <= FF_color;
            r_frame <= FF_frame[27:22];
            r_col   <= '0;
            r_row   <= '0;
            r_ready <= 1'b0;
            r_state <= S_CMD;
          end
        end
        S_CMD: begin
          if (w_cmd_push) r_state <= S_DATA2;
        end
        S_DATA2: begin
          if (w_beat2_push) begin
            r_state <= S_CMD;
            if (r_col == LAST_COL) begin
              r_col <= '0;
              if (r_row == LAST_ROW) begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
              end else begin
                r_row <= r_row + 10'd1;
              end
            end else begin
              r_col <= r_col + 7'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_filler.sv
// Directed bench for frame_filler: a 16x2 instance for handshake, stall,
// busy and reset cases, and an 800x4 instance for full-row geometry.
module tb_frame_filler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         valid;
  logic [23:0]  color;
  logic [31:0]  frame;
  logic         af_full, wdf_full;
  logic         ready, af_wr_en, wdf_wr_en;
  logic [30:0]  af_addr;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask;

  logic         b_valid;
  logic [23:0]  b_color;
  logic [31:0]  b_frame;
  logic         b_af_full, b_wdf_full;
  logic         b_ready, b_af_wr_en, b_wdf_wr_en;
  logic [30:0]  b_af_addr;
  logic [127:0] b_wdf_din;
  logic [15:0]  b_wdf_mask;

  frame_filler #(.H_PIXELS(16), .V_PIXELS(2)) dut (
    .clk(clk), .rst(rst), .FF_valid(valid), .FF_color(color), .FF_frame(frame),
    .FF_ready(ready), .af_full(af_full), .af_wr_en(af_wr_en), .af_addr_din(af_addr),
    .wdf_full(wdf_full), .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask)
  );

  frame_filler #(.H_PIXELS(800), .V_PIXELS(4)) dut_big (
    .clk(clk), .rst(rst), .FF_valid(b_valid), .FF_color(b_color), .FF_frame(b_frame),
    .FF_ready(b_ready), .af_full(b_af_full), .af_wr_en(b_af_wr_en), .af_addr_din(b_af_addr),
    .wdf_full(b_wdf_full), .wdf_wr_en(b_wdf_wr_en), .wdf_din(b_wdf_din),
    .wdf_mask_din(b_wdf_mask)
  );

  localparam logic [127:0] D_123456 = 128'h00123456_00123456_00123456_00123456;
  localparam logic [127:0] D_FF0000 = 128'h00FF0000_00FF0000_00FF0000_00FF0000;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO back-pressure generator; also randomises fulls during reset.
  bit bp_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      af_full  = 1'($urandom_range(0, 1));
      wdf_full = 1'($urandom_range(0, 1));
    end else begin
      af_full  = 1'b0;
      wdf_full = 1'b0;
    end
  end
  assign b_af_full  = 1'b0;
  assign b_wdf_full = 1'b0;

  // Push monitor, sampled mid-cycle.
  logic [30:0]  aq[$];
  logic [127:0] dq[$];
  int gate_err = 0, pair_err = 0, mask_err = 0, pend = 0;
  always @(negedge clk or negedge rst) begin
    if (!rst) pend = 0;
    else begin
      if (af_wr_en) begin
        if (af_full) gate_err++;
        aq.push_back(af_addr);
        if (!wdf_wr_en || pend != 0) pair_err++;
      end
      if (wdf_wr_en) begin
        if (wdf_full) gate_err++;
        if (wdf_mask != 16'h0) mask_err++;
        dq.push_back(wdf_din);
      end
      if (af_wr_en) pend = 1;
      else if (wdf_wr_en) begin
        if (pend != 1) pair_err++;
        pend = 0;
      end
    end
  end

  int b_af = 0, b_wdf = 0;
  logic [30:0] b_last = '0;
  always @(negedge clk) begin
    if (rst && b_af_wr_en) begin b_af++; b_last = b_af_addr; end
    if (rst && b_wdf_wr_en) b_wdf++;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_fill(input logic [23:0] c, input logic [31:0] f);
    valid = 1'b1; color = c; frame = f;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_ready(input bit big, input int bound, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!(big ? b_ready : ready) && n < bound);
  endtask

  task automatic chk_fill(input string tag, input int abase, input int dbase,
                          input logic [127:0] d);
    logic [30:0] exp_a[4];
    exp_a = '{31'h80000, 31'h80004, 31'h80200, 31'h80204};
    chk({tag, "_naf"}, 128'(aq.size() - abase), 128'd4);
    chk({tag, "_nwdf"}, 128'(dq.size() - dbase), 128'd8);
    for (int i = 0; i < 4; i++)
      if (abase + i < aq.size()) chk({tag, "_addr"}, 128'(aq[abase + i]), 128'(exp_a[i]));
    for (int i = 0; i < 8; i++)
      if (dbase + i < dq.size()) chk({tag, "_data"}, dq[dbase + i], d);
  endtask

  int n, ab, db, k;

  initial begin
    rst = 1'b0; valid = 1'b0; color = '0; frame = '0;
    b_valid = 1'b0; b_color = '0; b_frame = '0;

    // Reset held with random inputs.
    bp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid = 1'($urandom); color = 24'($urandom); frame = $urandom;
      cyc(1);
      chk("rst_ready", 128'(ready), 128'd0);
      chk("rst_af_en", 128'(af_wr_en), 128'd0);
      chk("rst_wdf_en", 128'(wdf_wr_en), 128'd0);
      chk("rst_addr", 128'(af_addr), 128'd0);
      chk("rst_din", wdf_din, 128'd0);
      chk("rst_mask", 128'(wdf_mask), 128'd0);
    end
    bp_en = 1'b0; valid = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(2);
    chk("post_rst_ready", 128'(ready), 128'd1);
    chk("post_rst_nowr", 128'(aq.size() + dq.size()), 128'd0);

    // Small fill, no stalls.
    ab = aq.size(); db = dq.size();
    start_fill(24'h123456, 32'h1040_0000);
    chk("lat_af_en", 128'(af_wr_en), 128'd1);
    chk("lat_addr", 128'(af_addr), 128'h80000);
    chk("busy_ready", 128'(ready), 128'd0);
    wait_ready(1'b0, 50, n);
    chk("fill_cycles", 128'(n), 128'd8);
    chk_fill("small", ab, db, D_123456);

    // Back-pressure.
    ab = aq.size(); db = dq.size();
    bp_en = 1'b1;
    start_fill(24'h123456, 32'h1040_0000);
    wait_ready(1'b0, 400, n);
    chk("bp_done", 128'(ready), 128'd1);
    bp_en = 1'b0;
    cyc(2);
    chk_fill("bp", ab, db, D_123456);

    // Requests while busy are ignored; the held one is taken on first IDLE cycle.
    ab = aq.size(); db = dq.size();
    start_fill(24'h123456, 32'h1040_0000);
    valid = 1'b1; color = 24'hFF0000;
    wait_ready(1'b0, 50, n);
    chk("busy_cycles", 128'(n), 128'd8);
    cyc(1);
    valid = 1'b0;
    chk("b2b_accept", 128'(ready), 128'd0);
    chk("b2b_af_en", 128'(af_wr_en), 128'd1);
    chk("b2b_data", wdf_din, D_FF0000);
    chk_fill("busy", ab, db, D_123456);
    wait_ready(1'b0, 50, n);
    chk("b2b_cycles", 128'(n), 128'd8);
    chk("b2b_naf", 128'(aq.size() - ab), 128'd8);

    // Reset mid-fill after the 2nd address push.
    ab = aq.size();
    start_fill(24'h123456, 32'h1040_0000);
    k = 0;
    while (aq.size() - ab < 2 && k < 50) begin @(negedge clk); k++; end
    chk("mid_reached", 128'(aq.size() - ab >= 2), 128'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_af_en", 128'(af_wr_en), 128'd0);
    chk("mid_wdf_en", 128'(wdf_wr_en), 128'd0);
    chk("mid_addr", 128'(af_addr), 128'd0);
    chk("mid_din", wdf_din, 128'd0);
    chk("mid_ready", 128'(ready), 128'd0);
    cyc(2);
    rst = 1'b1;
    ab = aq.size(); db = dq.size();
    cyc(1);
    chk("mid_post_ready", 128'(ready), 128'd1);
    cyc(20);
    chk("mid_no_af", 128'(aq.size() - ab), 128'd0);
    chk("mid_no_wdf", 128'(dq.size() - db), 128'd0);

    chk("gate_err", 128'(gate_err), 128'd0);
    chk("pair_err", 128'(pair_err), 128'd0);
    chk("mask_err", 128'(mask_err), 128'd0);

    // Full-width rows: 100 blocks x 4 rows.
    b_valid = 1'b1; b_color = 24'hABCDEF; b_frame = 32'h0FC0_0000;
    @(posedge clk); #1;
    b_valid = 1'b0;
    wait_ready(1'b1, 2000, n);
    chk("big_cycles", 128'(n), 128'd800);
    @(negedge clk);
    chk("big_naf", 128'(b_af), 128'd400);
    chk("big_nwdf", 128'(b_wdf), 128'd800);
    chk("big_last", 128'(b_last), 128'h1F8078C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
